// File: rtl/frankie_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : frankie_sequencer
//  Purpose  : Multicycle state sequencer for the "Frankie" CPU. Steps each
//             instruction through FETCH -> DECODE -> EXEC (1..MAX_EXEC
//             cycles, programmable per opcode) with a memory-wait state, a
//             global stall, a halt opcode and cycle/retire counters.
//  Ports    :
//    CLK          clock, all state changes on the rising edge
//    Reset        synchronous active-low reset
//    OPCODE       opcode from the instruction register (used in DECODE)
//    MemReq       current EXEC step performs a memory access
//    MemReady     memory completes the access this cycle
//    Stall        freeze the sequencer
//    CfgWe        length-table write enable
//    CfgOpcode    length-table index to write
//    CfgLen       execute length to store (clamped into 1..MAX_EXEC)
//    Phase        0=FETCH 1=DECODE 2=EXEC 3=WAIT 4=HALT
//    ExecStep     current execute step (0 outside EXEC / WAIT-from-EXEC)
//    FetchPulse   instruction fetch cycle
//    InstWrite    IR / decode latch enable
//    LastStep     current execute step is the final one
//    Retire       instruction completes this cycle
//    Halted       sequencer is in HALT
//    CycleCount   cycles since reset, HALT cycles excluded
//    RetireCount  retired instructions
//  Revision : 1.0 - initial release
// ============================================================================
module frankie_sequencer #(
    parameter int              OPW         = 5,
    parameter int              MAX_EXEC    = 4,
    parameter int              SW          = 2,
    parameter int              CNTW        = 32,
    parameter logic [OPW-1:0]  HALT_OPCODE = 5'b11111
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OPW-1:0]  OPCODE,
    input  logic            MemReq,
    input  logic            MemReady,
    input  logic            Stall,
    input  logic            CfgWe,
    input  logic [OPW-1:0]  CfgOpcode,
    input  logic [SW:0]     CfgLen,
    output logic [2:0]      Phase,
    output logic [SW-1:0]   ExecStep,
    output logic            FetchPulse,
    output logic            InstWrite,
    output logic            LastStep,
    output logic            Retire,
    output logic            Halted,
    output logic [CNTW-1:0] CycleCount,
    output logic [CNTW-1:0] RetireCount
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WAIT   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic       ORG_FETCH = 1'b0;
    localparam logic       ORG_EXEC  = 1'b1;
    localparam logic [SW:0] LEN_ONE  = (SW+1)'(1);
    localparam logic [SW:0] LEN_MAX  = (SW+1)'(MAX_EXEC);
    localparam int          NUM_OPS  = 2**OPW;

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [SW:0]     len_q, len_d;
    logic            origin_q, origin_d;
    logic [SW:0]     len_table_q [NUM_OPS];
    logic [CNTW-1:0] cycle_cnt_q;
    logic [CNTW-1:0] retire_cnt_q;

    logic            w_exec_like;
    logic            w_last;
    logic            w_mem_block;
    logic            w_retire;
    logic [SW:0]     w_cfg_len;

    // Stored lengths are always legal, so the EXEC counter never needs
    // to handle a zero or oversize length.
    always_comb begin
        if (CfgLen == '0) begin
            w_cfg_len = LEN_ONE;
        end else if (CfgLen > LEN_MAX) begin
            w_cfg_len = LEN_MAX;
        end else begin
            w_cfg_len = CfgLen;
        end
    end

    // WAIT entered from EXEC keeps presenting the step it is waiting on.
    assign w_exec_like = (state_q == S_EXEC) ||
                         ((state_q == S_WAIT) && (origin_q == ORG_EXEC));
    assign w_last      = w_exec_like && ({1'b0, step_q} == (len_q - LEN_ONE));
    assign w_mem_block = MemReq && !MemReady;

    assign w_retire = Reset && !Stall && w_last &&
                      (((state_q == S_EXEC) && !w_mem_block) ||
                       ((state_q == S_WAIT) && MemReady));

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        len_d    = len_q;
        origin_d = origin_q;
        if (!Stall) begin
            case (state_q)
                S_FETCH: begin
                    if (MemReady) begin
                        state_d = S_DECODE;
                    end else begin
                        state_d  = S_WAIT;
                        origin_d = ORG_FETCH;
                    end
                end
                S_DECODE: begin
                    // Non-blocking table write means a same-cycle write to
                    // this index is not visible here; the old length is used.
                    len_d  = len_table_q[OPCODE];
                    step_d = '0;
                    state_d = (OPCODE == HALT_OPCODE) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    if (w_mem_block) begin
                        state_d  = S_WAIT;
                        origin_d = ORG_EXEC;
                    end else if (w_last) begin
                        state_d = S_FETCH;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
                S_WAIT: begin
                    if (MemReady) begin
                        if (origin_q == ORG_FETCH) begin
                            state_d = S_DECODE;
                        end else if (w_last) begin
                            state_d = S_FETCH;
                            step_d  = '0;
                        end else begin
                            state_d = S_EXEC;
                            step_d  = step_q + SW'(1);
                        end
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                    step_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q      <= S_FETCH;
            step_q       <= '0;
            len_q        <= LEN_ONE;
            origin_q     <= ORG_FETCH;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            for (int i = 0; i < NUM_OPS; i++) begin
                len_table_q[i] <= LEN_ONE;
            end
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            len_q    <= len_d;
            origin_q <= origin_d;
            if (CfgWe) begin
                len_table_q[CfgOpcode] <= w_cfg_len;
            end
            // Stall does not stop the cycle counter; only HALT does.
            if (state_q != S_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + CNTW'(1);
            end
            if (w_retire) begin
                retire_cnt_q <= retire_cnt_q + CNTW'(1);
            end
        end
    end

    assign Phase       = state_q;
    assign ExecStep    = step_q;
    assign FetchPulse  = Reset && !Stall && (state_q == S_FETCH);
    assign InstWrite   = Reset && !Stall && (state_q == S_DECODE);
    assign LastStep    = w_last;
    assign Retire      = w_retire;
    assign Halted      = (state_q == S_HALT);
    assign CycleCount  = cycle_cnt_q;
    assign RetireCount = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frankie_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frankie_sequencer
//  Purpose  : Directed scoreboard bench for frankie_sequencer. The stimulus
//             process drives one cycle of inputs and pushes the hand-derived
//             expected outputs for that cycle; a monitor pops and compares
//             on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frankie_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [4:0]  OPCODE;
    logic        MemReq, MemReady, Stall, CfgWe;
    logic [4:0]  CfgOpcode;
    logic [2:0]  CfgLen;
    logic [2:0]  Phase;
    logic [1:0]  ExecStep;
    logic        FetchPulse, InstWrite, LastStep, Retire, Halted;
    logic [31:0] CycleCount, RetireCount;

    frankie_sequencer dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .OPCODE     (OPCODE),
        .MemReq     (MemReq),
        .MemReady   (MemReady),
        .Stall      (Stall),
        .CfgWe      (CfgWe),
        .CfgOpcode  (CfgOpcode),
        .CfgLen     (CfgLen),
        .Phase      (Phase),
        .ExecStep   (ExecStep),
        .FetchPulse (FetchPulse),
        .InstWrite  (InstWrite),
        .LastStep   (LastStep),
        .Retire     (Retire),
        .Halted     (Halted),
        .CycleCount (CycleCount),
        .RetireCount(RetireCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic [73:0] v;   // {Phase, ExecStep, Last, Fetch, InstWr, Retire, Halted, Cyc, Ret}
    } exp_t;

    exp_t q_exp[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Monitor: every cycle with a queued expectation is compared.
    always @(negedge CLK) begin
        exp_t        e;
        logic [73:0] act;
        if (q_exp.size() != 0) begin
            e   = q_exp.pop_front();
            act = {Phase, ExecStep, LastStep, FetchPulse, InstWrite, Retire,
                   Halted, CycleCount, RetireCount};
            n_vec++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got ph=%0d st=%0d last=%b fp=%b iw=%b ret=%b hlt=%b cyc=%0d rc=%0d, want ph=%0d st=%0d last=%b fp=%b iw=%b ret=%b hlt=%b cyc=%0d rc=%0d",
                         e.nm, act[73:71], act[70:69], act[68], act[67], act[66],
                         act[65], act[64], act[63:32], act[31:0],
                         e.v[73:71], e.v[70:69], e.v[68], e.v[67], e.v[66],
                         e.v[65], e.v[64], e.v[63:32], e.v[31:0]);
            end
        end
    end

    // One cycle: drive inputs, queue the expectation, advance to next edge.
    task automatic cyc(input string nm, input logic rdy, input logic req,
                       input logic stl, input logic [4:0] op,
                       input logic [2:0] ph, input logic [1:0] st,
                       input logic last, input logic fp, input logic iw,
                       input logic ret, input logic hlt,
                       input int cy, input int rc);
        exp_t e;
        MemReady = rdy;
        MemReq   = req;
        Stall    = stl;
        OPCODE   = op;
        e.nm = nm;
        e.v  = {ph, st, last, fp, iw, ret, hlt, 32'(cy), 32'(rc)};
        q_exp.push_back(e);
        @(posedge CLK);
        #1;
        CfgWe = 1'b0;
    endtask

    task automatic cfg(input logic [4:0] op, input logic [2:0] len);
        CfgWe     = 1'b1;
        CfgOpcode = op;
        CfgLen    = len;
    endtask

    initial begin
        Reset = 1'b0; OPCODE = '0; MemReq = 1'b0; MemReady = 1'b1;
        Stall = 1'b0; CfgWe = 1'b0; CfgOpcode = '0; CfgLen = '0;
        repeat (2) @(posedge CLK);
        #1;
        // reset state, pulses gated while Reset is low
        cyc("reset",      1,0,0, 5'd2, 3'd0,2'd0, 0,0,0,0,0,  0,0);
        Reset = 1'b1;

        // 1: default length-1 instruction
        cyc("t1_fetch",   1,0,0, 5'd2, 3'd0,2'd0, 0,1,0,0,0,  0,0);
        cyc("t1_decode",  1,0,0, 5'd2, 3'd1,2'd0, 0,0,1,0,0,  1,0);
        cyc("t1_exec",    1,0,0, 5'd2, 3'd2,2'd0, 1,0,0,1,0,  2,0);

        // 2: opcode 2 programmed to length 3
        cfg(5'd2, 3'd3);
        cyc("t2_fetch",   1,0,0, 5'd2, 3'd0,2'd0, 0,1,0,0,0,  3,1);
        cyc("t2_decode",  1,0,0, 5'd2, 3'd1,2'd0, 0,0,1,0,0,  4,1);
        cyc("t2_step0",   1,0,0, 5'd2, 3'd2,2'd0, 0,0,0,0,0,  5,1);
        cyc("t2_step1",   1,0,0, 5'd2, 3'd2,2'd1, 0,0,0,0,0,  6,1);
        cyc("t2_step2",   1,0,0, 5'd2, 3'd2,2'd2, 1,0,0,1,0,  7,1);

        // 3: CfgLen 0 -> 1, CfgLen 7 -> 4
        cfg(5'd3, 3'd0);
        cyc("t3a_fetch",  1,0,0, 5'd3, 3'd0,2'd0, 0,1,0,0,0,  8,2);
        cfg(5'd4, 3'd7);
        cyc("t3a_decode", 1,0,0, 5'd3, 3'd1,2'd0, 0,0,1,0,0,  9,2);
        cyc("t3a_exec",   1,0,0, 5'd3, 3'd2,2'd0, 1,0,0,1,0, 10,2);
        cyc("t3b_fetch",  1,0,0, 5'd4, 3'd0,2'd0, 0,1,0,0,0, 11,3);
        cyc("t3b_decode", 1,0,0, 5'd4, 3'd1,2'd0, 0,0,1,0,0, 12,3);
        cyc("t3b_step0",  1,0,0, 5'd4, 3'd2,2'd0, 0,0,0,0,0, 13,3);
        cyc("t3b_step1",  1,0,0, 5'd4, 3'd2,2'd1, 0,0,0,0,0, 14,3);
        cyc("t3b_step2",  1,0,0, 5'd4, 3'd2,2'd2, 0,0,0,0,0, 15,3);
        cyc("t3b_step3",  1,0,0, 5'd4, 3'd2,2'd3, 1,0,0,1,0, 16,3);

        // same-cycle write and decode of opcode 2: old length 3 is used
        cyc("t3c_fetch",  1,0,0, 5'd2, 3'd0,2'd0, 0,1,0,0,0, 17,4);
        cfg(5'd2, 3'd2);
        cyc("t3c_decode", 1,0,0, 5'd2, 3'd1,2'd0, 0,0,1,0,0, 18,4);
        cyc("t3c_step0",  1,0,0, 5'd2, 3'd2,2'd0, 0,0,0,0,0, 19,4);
        cyc("t3c_step1",  1,0,0, 5'd2, 3'd2,2'd1, 0,0,0,0,0, 20,4);
        cyc("t3c_step2",  1,0,0, 5'd2, 3'd2,2'd2, 1,0,0,1,0, 21,4);

        // 4: fetch wait, then exec wait at step 1 of a length-3 opcode
        cfg(5'd5, 3'd3);
        cyc("t4_fetchw",  0,0,0, 5'd5, 3'd0,2'd0, 0,1,0,0,0, 22,5);
        cyc("t4_waitf",   1,0,0, 5'd5, 3'd3,2'd0, 0,0,0,0,0, 23,5);
        cyc("t4_decode",  1,0,0, 5'd5, 3'd1,2'd0, 0,0,1,0,0, 24,5);
        cyc("t4_step0",   1,0,0, 5'd5, 3'd2,2'd0, 0,0,0,0,0, 25,5);
        cyc("t4_step1m",  0,1,0, 5'd5, 3'd2,2'd1, 0,0,0,0,0, 26,5);
        cyc("t4_wait1",   0,1,0, 5'd5, 3'd3,2'd1, 0,0,0,0,0, 27,5);
        cyc("t4_wait2",   0,1,0, 5'd5, 3'd3,2'd1, 0,0,0,0,0, 28,5);
        cyc("t4_wait3",   1,1,0, 5'd5, 3'd3,2'd1, 0,0,0,0,0, 29,5);
        cyc("t4_step2",   1,0,0, 5'd5, 3'd2,2'd2, 1,0,0,1,0, 30,5);

        // wait on a final step retires from WAIT
        cyc("t4b_fetch",  1,0,0, 5'd1, 3'd0,2'd0, 0,1,0,0,0, 31,6);
        cyc("t4b_decode", 1,0,0, 5'd1, 3'd1,2'd0, 0,0,1,0,0, 32,6);
        cyc("t4b_exec",   0,1,0, 5'd1, 3'd2,2'd0, 1,0,0,0,0, 33,6);
        cyc("t4b_wait",   1,1,0, 5'd1, 3'd3,2'd0, 1,0,0,1,0, 34,6);

        // 5: stall 4 cycles at EXEC step 1
        cyc("t5_fetch",   1,0,0, 5'd5, 3'd0,2'd0, 0,1,0,0,0, 35,7);
        cyc("t5_decode",  1,0,0, 5'd5, 3'd1,2'd0, 0,0,1,0,0, 36,7);
        cyc("t5_step0",   1,0,0, 5'd5, 3'd2,2'd0, 0,0,0,0,0, 37,7);
        cyc("t5_stall1",  1,0,1, 5'd5, 3'd2,2'd1, 0,0,0,0,0, 38,7);
        cyc("t5_stall2",  1,0,1, 5'd5, 3'd2,2'd1, 0,0,0,0,0, 39,7);
        cyc("t5_stall3",  1,0,1, 5'd5, 3'd2,2'd1, 0,0,0,0,0, 40,7);
        cyc("t5_stall4",  1,0,1, 5'd5, 3'd2,2'd1, 0,0,0,0,0, 41,7);
        cyc("t5_step1",   1,0,0, 5'd5, 3'd2,2'd1, 0,0,0,0,0, 42,7);
        cyc("t5_step2",   1,0,0, 5'd5, 3'd2,2'd2, 1,0,0,1,0, 43,7);
        cyc("t5_fstall",  1,0,1, 5'd5, 3'd0,2'd0, 0,0,0,0,0, 44,8);
        cyc("t5_fetch2",  1,0,0, 5'd5, 3'd0,2'd0, 0,1,0,0,0, 45,8);

        // 6: halt opcode, counters frozen, reset clears everything
        cyc("t6_dechalt", 1,0,0, 5'd31, 3'd1,2'd0, 0,0,1,0,0, 46,8);
        cfg(5'd5, 3'd4);
        cyc("t6_halt1",   1,0,0, 5'd31, 3'd4,2'd0, 0,0,0,0,1, 47,8);
        cyc("t6_halt2",   1,0,1, 5'd31, 3'd4,2'd0, 0,0,0,0,1, 47,8);
        Reset = 1'b0;
        cyc("t6_rstlow",  1,0,0, 5'd5, 3'd4,2'd0, 0,0,0,0,1, 47,8);
        Reset = 1'b1;
        cyc("t6_fetch",   1,0,0, 5'd5, 3'd0,2'd0, 0,1,0,0,0,  0,0);
        cyc("t6_decode",  1,0,0, 5'd5, 3'd1,2'd0, 0,0,1,0,0,  1,0);
        cyc("t6_exec1",   1,0,0, 5'd5, 3'd2,2'd0, 1,0,0,1,0,  2,0);
        cyc("t6_after",   1,0,0, 5'd5, 3'd0,2'd0, 0,1,0,0,0,  3,1);

        @(negedge CLK);
        #1;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
